// File: rtl/clk_div_ctrl.sv
// Runtime-programmable tick/clock divider with a valid/ready divisor update path.
// New divisors are committed only at a terminal count so no runt periods appear.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 18,
  parameter int unsigned DEFAULT_DIV = 100000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PENDING = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_err_q, cfg_err_d;

  logic accept;
  logic legal;
  logic tc;

  assign cfg_ready = (state_q != PENDING);
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = (cfg_div >= MIN_D);
  assign tc        = (count_q == (div_q - ONE));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pend_d    = pend_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    cfg_err_d = accept & ~legal;

    case (state_q)
      IDLE: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        if (accept && legal) div_d = cfg_div;
        if (enable) state_d = RUN;
      end
      RUN, PENDING: begin
        if (!enable) begin
          // Stopping commits whatever divisor is outstanding, pending or just offered.
          state_d   = IDLE;
          count_d   = '0;
          clk_out_d = 1'b0;
          if (state_q == PENDING) div_d = pend_q;
          else if (accept && legal) div_d = cfg_div;
        end else begin
          if (tc) begin
            count_d   = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
          end else begin
            count_d = count_q + ONE;
          end
          if (state_q == PENDING) begin
            if (tc) begin
              div_d   = pend_q;
              state_d = RUN;
            end
          end else if (accept && legal) begin
            pend_d  = cfg_div;
            state_d = PENDING;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= DEF_DIV;
      pend_q    <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign count   = count_q;
  assign state   = state_q;

endmodule
